// File: rtl/npn_sweep_ctrl_if.sv
// rtl/npn_sweep_ctrl_if.sv - host-side bundle between a test harness and npn_sweep_ctrl
// Purpose: groups the sweep request, NPN configuration and result signals.
// Signals:
//   start, abort         host requests (master drives)
//   perm[7:0]            field i = perm[2i+1:2i], logical variable driving physical x_i
//   neg_mask[3:0]        physical input inversion mask
//   neg_out              sampled output inversion
//   expected[15:0]       reference truth table
//   busy, done           sweep status (slave drives)
//   truth_table[15:0]    last completed table, bit m = f(minterm m)
//   match, cfg_err       comparison result / invalid permutation flag
interface npn_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [7:0]  perm;
  logic [3:0]  neg_mask;
  logic        neg_out;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic        match;
  logic        cfg_err;

  modport master (
    output start, abort, perm, neg_mask, neg_out, expected,
    input  busy, done, truth_table, match, cfg_err
  );

  modport slave (
    input  start, abort, perm, neg_mask, neg_out, expected,
    output busy, done, truth_table, match, cfg_err
  );
endinterface

// File: rtl/npn_sweep_ctrl.sv
// rtl/npn_sweep_ctrl.sv - NPN-transformed 16-minterm sweep of a 4-input function block
// Purpose: drives x0..x3 through all 16 minterms under a captured permutation and
//   negation, samples y0 per minterm into a shadow table, then publishes the table
//   and its comparison with the captured expected table.
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_i          synchronous active-high reset
//   host           npn_sweep_ctrl_if.slave: request, configuration and results
//   x0_o..x3_o     registered drive to the function block
//   y0_i           function block output
module npn_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  npn_sweep_ctrl_if.slave       host,
  output logic                  x0_o,
  output logic                  x1_o,
  output logic                  x2_o,
  output logic                  x3_o,
  input  logic                  y0_i
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  perm_q, perm_d;
  logic [3:0]  negm_q, negm_d;
  logic        nego_q, nego_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  x_q, x_d;
  logic [15:0] tt_q, tt_d;
  logic        match_q, match_d;
  logic        cfg_err_q, cfg_err_d;
  logic        sample;
  logic [15:0] full;

  // Physical input i takes logical variable perm field i, optionally inverted.
  function automatic logic [3:0] map_vec(input logic [3:0] m, input logic [7:0] p,
                                         input logic [3:0] n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = m[p[2*i +: 2]] ^ n[i];
    end
    return r;
  endfunction

  function automatic logic perm_ok(input logic [7:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (p[2*i +: 2] == p[2*j +: 2]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      hold_q    <= '0;
      perm_q    <= '0;
      negm_q    <= '0;
      nego_q    <= 1'b0;
      exp_q     <= '0;
      shadow_q  <= '0;
      x_q       <= '0;
      tt_q      <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hold_q    <= hold_d;
      perm_q    <= perm_d;
      negm_q    <= negm_d;
      nego_q    <= nego_d;
      exp_q     <= exp_d;
      shadow_q  <= shadow_d;
      x_q       <= x_d;
      tt_q      <= tt_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    hold_d    = hold_q;
    perm_d    = perm_q;
    negm_d    = negm_q;
    nego_d    = nego_q;
    exp_d     = exp_q;
    shadow_d  = shadow_q;
    x_d       = x_q;
    tt_d      = tt_q;
    match_d   = match_q;
    cfg_err_d = cfg_err_q;
    sample    = y0_i ^ nego_q;
    full      = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (host.start && !host.abort) begin
          perm_d = host.perm;
          negm_d = host.neg_mask;
          nego_d = host.neg_out;
          exp_d  = host.expected;
          if (!perm_ok(host.perm)) begin
            // Invalid permutation: report through the FIN done pulse, table untouched.
            cfg_err_d = 1'b1;
            match_d   = 1'b0;
            state_d   = S_FIN;
          end else begin
            cfg_err_d = 1'b0;
            m_d       = '0;
            hold_d    = '0;
            shadow_d  = '0;
            x_d       = map_vec(4'd0, host.perm, host.neg_mask);
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (host.abort) begin
          x_d     = '0;
          state_d = S_IDLE;
        end else if (hold_q == SETTLE_LAST) begin
          hold_d   = '0;
          full[m_q] = sample;
          shadow_d = full;
          if (m_q == 4'd15) begin
            // Publish on entry to FIN so results are valid alongside done.
            x_d     = '0;
            tt_d    = full;
            match_d = (full == exp_q);
            state_d = S_FIN;
          end else begin
            m_d = m_q + 4'd1;
            x_d = map_vec(m_q + 4'd1, perm_q, negm_q);
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign host.busy        = (state_q == S_RUN);
  assign host.done        = (state_q == S_FIN);
  assign host.truth_table = tt_q;
  assign host.match       = match_q;
  assign host.cfg_err     = cfg_err_q;

  assign x0_o = x_q[0];
  assign x1_o = x_q[1];
  assign x2_o = x_q[2];
  assign x3_o = x_q[3];

endmodule
